// File: rtl/instr_fetch_unit.sv
// RV32I fetch stage: owns the PC, hides the registered-ROM read latency and hands words to decode via valid/ready.
// Start-to-valid latency is 3 cycles; the IR holds until consumed. FETCH_ILLEGAL_CHECK_EN adds the o_illegal flag.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          ADDR_W    = 14,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_fetch_start,
  input  logic              i_pc_we,
  input  logic [31:0]       i_pc_next,
  output logic [ADDR_W-1:0] o_rom_addr,
  input  logic [31:0]       i_rom_data,
  output logic [31:0]       o_instr,
  output logic              o_instr_valid,
  input  logic              i_instr_ready,
  output logic [31:0]       o_pc,
  output logic [31:0]       o_pc_plus4,
  output logic              o_fetch_busy,
`ifdef FETCH_ILLEGAL_CHECK_EN
  output logic              o_illegal,
`endif
  output logic              o_fault
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    CAPT  = 2'd2,
    VALID = 2'd3
  } state_t;

  state_t      state;
  logic [31:0] pc;

  assign o_rom_addr   = pc[ADDR_W-1:0];
  assign o_pc_plus4   = o_pc + 32'd4;
  assign o_fetch_busy = (state == REQ) || (state == CAPT);

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      pc            <= RESET_PC;
      o_instr       <= NOP_INSTR;
      o_instr_valid <= 1'b0;
      o_pc          <= RESET_PC;
      o_fault       <= 1'b0;
    end else begin
      o_fault <= 1'b0;
      // Redirect wins over everything, including a same-cycle handshake or start.
      if (i_pc_we) begin
        pc            <= i_pc_next;
        o_instr_valid <= 1'b0;
        state         <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (i_fetch_start) begin
              if (pc[1:0] == 2'b00) state <= REQ;
              else                  o_fault <= 1'b1;
            end
          end
          REQ: state <= CAPT;
          CAPT: begin
            o_instr       <= i_rom_data;
            o_pc          <= pc;
            o_instr_valid <= 1'b1;
            state         <= VALID;
          end
          VALID: begin
            if (i_instr_ready) begin
              pc            <= pc + 32'd4;
              o_instr_valid <= 1'b0;
              state         <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

`ifdef FETCH_ILLEGAL_CHECK_EN
  // Zero is what the ROM returns past its contents; RV32I words always end in 2'b11.
  always_ff @(posedge clk) begin
    if (rst || i_pc_we) begin
      o_illegal <= 1'b0;
    end else if (state == CAPT) begin
      o_illegal <= (i_rom_data == 32'h0000_0000) || (i_rom_data[1:0] != 2'b11);
    end else if (state == VALID && i_instr_ready) begin
      o_illegal <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a one-cycle registered ROM model.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_fetch_start = 1'b0;
  logic        i_pc_we = 1'b0;
  logic [31:0] i_pc_next = 32'h0;
  logic [13:0] o_rom_addr;
  logic [31:0] i_rom_data = 32'h0;
  logic [31:0] o_instr;
  logic        o_instr_valid;
  logic        i_instr_ready = 1'b0;
  logic [31:0] o_pc;
  logic [31:0] o_pc_plus4;
  logic        o_fetch_busy;
  logic        o_fault;
`ifdef FETCH_ILLEGAL_CHECK_EN
  logic        o_illegal;
`endif

  int n_vec = 0;
  int n_err = 0;

  instr_fetch_unit dut (
    .clk           (clk),
    .rst           (rst),
    .i_fetch_start (i_fetch_start),
    .i_pc_we       (i_pc_we),
    .i_pc_next     (i_pc_next),
    .o_rom_addr    (o_rom_addr),
    .i_rom_data    (i_rom_data),
    .o_instr       (o_instr),
    .o_instr_valid (o_instr_valid),
    .i_instr_ready (i_instr_ready),
    .o_pc          (o_pc),
    .o_pc_plus4    (o_pc_plus4),
    .o_fetch_busy  (o_fetch_busy),
`ifdef FETCH_ILLEGAL_CHECK_EN
    .o_illegal     (o_illegal),
`endif
    .o_fault       (o_fault)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rom_word(input logic [13:0] a);
    case (a)
      14'h0000: rom_word = 32'h800000b7;
      14'h0004: rom_word = 32'h00000113;
      14'h05a0: rom_word = 32'h00100193;
      14'h3ffc: rom_word = 32'h00a00093;
      default:  rom_word = 32'h00000000;
    endcase
  endfunction

  always @(posedge clk) i_rom_data <= rom_word(o_rom_addr);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, got, want);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Start in the current cycle, return positioned in the VALID cycle.
  task automatic fetch;
    i_fetch_start = 1'b1;
    tick();
    i_fetch_start = 1'b0;
    tick();
    tick();
  endtask

  task automatic redirect(input logic [31:0] tgt);
    i_pc_we   = 1'b1;
    i_pc_next = tgt;
    tick();
    i_pc_we   = 1'b0;
  endtask

  initial begin
    tick();
    tick();
    rst = 1'b0;
    chk("rst_instr", o_instr, 32'h00000013);
    chk("rst_valid", o_instr_valid, 0);
    chk("rst_pc", o_pc, 0);
    chk("rst_fault", o_fault, 0);
    chk("rst_busy", o_fetch_busy, 0);
    chk("rst_addr", o_rom_addr, 0);

    // First fetch: valid exactly three cycles after start.
    i_fetch_start = 1'b1;
    tick();
    i_fetch_start = 1'b0;
    chk("f0_req_addr", o_rom_addr, 0);
    chk("f0_req_busy", o_fetch_busy, 1);
    chk("f0_req_valid", o_instr_valid, 0);
    tick();
    chk("f0_capt_valid", o_instr_valid, 0);
    tick();
    chk("f0_valid", o_instr_valid, 1);
    chk("f0_instr", o_instr, 32'h800000b7);
    chk("f0_pc", o_pc, 0);
    chk("f0_pc4", o_pc_plus4, 4);
    chk("f0_busy", o_fetch_busy, 0);

    i_instr_ready = 1'b1;
    tick();
    i_instr_ready = 1'b0;
    chk("hs0_valid", o_instr_valid, 0);
    chk("hs0_addr", o_rom_addr, 4);
    chk("hs0_hold", o_instr, 32'h800000b7);

    // Second fetch, then backpressure with a stray start that must be ignored.
    fetch();
    chk("f4_instr", o_instr, 32'h00000113);
    chk("f4_pc", o_pc, 4);
    chk("f4_pc4", o_pc_plus4, 8);
    for (int i = 0; i < 5; i++) begin
      i_fetch_start = (i == 0);
      tick();
    end
    i_fetch_start = 1'b0;
    chk("bp_valid", o_instr_valid, 1);
    chk("bp_instr", o_instr, 32'h00000113);
    chk("bp_addr", o_rom_addr, 4);
    chk("bp_busy", o_fetch_busy, 0);
    i_instr_ready = 1'b1;
    i_fetch_start = 1'b1;
    tick();
    i_instr_ready = 1'b0;
    i_fetch_start = 1'b0;
    chk("hs1_valid", o_instr_valid, 0);
    chk("hs1_addr", o_rom_addr, 8);
    tick();
    chk("hs1_nostart", o_fetch_busy, 0);

    // Redirect during CAPT squashes the fetch.
    i_fetch_start = 1'b1;
    tick();
    i_fetch_start = 1'b0;
    tick();
    redirect(32'h5a0);
    chk("sq_valid", o_instr_valid, 0);
    chk("sq_busy", o_fetch_busy, 0);
    chk("sq_ir", o_instr, 32'h00000113);
    chk("sq_addr", o_rom_addr, 14'h05a0);
    tick();
    chk("sq_valid2", o_instr_valid, 0);
    fetch();
    chk("f5a0_instr", o_instr, 32'h00100193);
    chk("f5a0_pc", o_pc, 32'h5a0);

    // Redirect plus handshake in VALID: redirect wins, no +4.
    i_instr_ready = 1'b1;
    redirect(32'h5b4);
    i_instr_ready = 1'b0;
    chk("rv_valid", o_instr_valid, 0);
    chk("rv_addr", o_rom_addr, 14'h05b4);
    fetch();
    chk("f5b4_instr", o_instr, 32'h0);
    chk("f5b4_pc", o_pc, 32'h5b4);
`ifdef FETCH_ILLEGAL_CHECK_EN
    chk("ill_zero", o_illegal, 1);
`endif
    i_instr_ready = 1'b1;
    tick();
    i_instr_ready = 1'b0;
    chk("f5b4_next", o_rom_addr, 14'h05b8);
`ifdef FETCH_ILLEGAL_CHECK_EN
    chk("ill_clr", o_illegal, 0);
`endif
    redirect(32'h0);
    fetch();
    chk("f0b_instr", o_instr, 32'h800000b7);
`ifdef FETCH_ILLEGAL_CHECK_EN
    chk("ill_ok", o_illegal, 0);
`endif

    // Misaligned PC: one-cycle fault, no request.
    redirect(32'h6);
    i_fetch_start = 1'b1;
    tick();
    i_fetch_start = 1'b0;
    chk("mis_fault", o_fault, 1);
    chk("mis_busy", o_fetch_busy, 0);
    tick();
    chk("mis_fault_off", o_fault, 0);
    chk("mis_busy2", o_fetch_busy, 0);
    chk("mis_addr", o_rom_addr, 6);

    // Redirect and start together in IDLE: start ignored.
    i_fetch_start = 1'b1;
    redirect(32'hffff_fffc);
    i_fetch_start = 1'b0;
    chk("rs_busy", o_fetch_busy, 0);
    chk("rs_fault", o_fault, 0);
    chk("rs_addr", o_rom_addr, 14'h3ffc);
    fetch();
    chk("wrap_instr", o_instr, 32'h00a00093);
    chk("wrap_pc", o_pc, 32'hffff_fffc);
    chk("wrap_pc4", o_pc_plus4, 0);
    i_instr_ready = 1'b1;
    tick();
    i_instr_ready = 1'b0;
    chk("wrap_addr", o_rom_addr, 0);

    // Reset during REQ aborts; the late ROM word is dropped.
    redirect(32'h4);
    i_fetch_start = 1'b1;
    tick();
    i_fetch_start = 1'b0;
    chk("ab_busy", o_fetch_busy, 1);
    chk("ab_addr", o_rom_addr, 4);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("ab_idle", o_fetch_busy, 0);
    chk("ab_valid", o_instr_valid, 0);
    chk("ab_pc", o_rom_addr, 0);
    chk("ab_opc", o_pc, 0);
    chk("ab_ir", o_instr, 32'h00000013);
    tick();
    tick();
    chk("ab_valid2", o_instr_valid, 0);
    chk("ab_ir2", o_instr, 32'h00000013);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
